// File: rtl/neopixel_rx.sv
// WS2812 line decoder: classifies high-pulse widths into bits, assembles 24-bit
// pixels onto a pixel_memory-style write port and flags the latch gap as end of frame.
module neopixel_rx #(
   parameter int unsigned N_PIXELS     = 256,
   parameter int unsigned ADDR_W       = 8,
   parameter int unsigned T_HIGH_MIN   = 5,
   parameter int unsigned T_BIT_THRESH = 30,
   parameter int unsigned T_HIGH_MAX   = 60,
   parameter int unsigned T_RESET_LOW  = 2500
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_din,
   input  logic              i_err_clr,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic              o_wr_en,
   output logic [23:0]       o_wr_data,
   output logic              o_frame_done,
   output logic [ADDR_W:0]   o_pixel_count,
   output logic              o_busy,
   output logic              o_err,
   output logic              o_ovf
);

   localparam int unsigned CNT_W = $clog2(T_RESET_LOW + 1);
   localparam logic [CNT_W-1:0] L_ONE      = CNT_W'(1);
   localparam logic [CNT_W-1:0] L_HMIN     = CNT_W'(T_HIGH_MIN);
   localparam logic [CNT_W-1:0] L_THRESH   = CNT_W'(T_BIT_THRESH);
   localparam logic [CNT_W-1:0] L_HMAX     = CNT_W'(T_HIGH_MAX);
   localparam logic [CNT_W-1:0] L_RST_LAST = CNT_W'(T_RESET_LOW - 1);
   localparam logic [ADDR_W:0]  L_NPIX     = (ADDR_W + 1)'(N_PIXELS);

   typedef enum logic [1:0] {S_SYNC, S_IDLE, S_HIGH, S_LOW} state_t;

   state_t            r_state, w_state_next;
   logic              r_din_s1, r_din_s2, r_din_prev;
   logic [CNT_W-1:0]  r_cnt, w_cnt_next;
   logic [23:0]       r_shift;
   logic [4:0]        r_bitcnt;
   logic [ADDR_W:0]   r_index;
   logic              r_wr_en, r_frame_done, r_busy, r_err, r_ovf;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [23:0]       r_wr_data;
   logic [ADDR_W:0]   r_pixel_count;

   logic w_rise, w_fall, w_bit_done, w_bit_val, w_latch, w_timing_err;
   logic [23:0] w_shift_next;

   assign w_rise       = r_din_s2 & ~r_din_prev;
   assign w_fall       = ~r_din_s2 & r_din_prev;
   assign w_shift_next = {r_shift[22:0], w_bit_val};

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_din_s1   <= 1'b0;
         r_din_s2   <= 1'b0;
         r_din_prev <= 1'b0;
         r_state    <= S_SYNC;
         r_cnt      <= '0;
      end else begin
         r_din_s1   <= i_din;
         r_din_s2   <= r_din_s1;
         r_din_prev <= r_din_s2;
         r_state    <= w_state_next;
         r_cnt      <= w_cnt_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_bit_done   = 1'b0;
      w_bit_val    = 1'b0;
      w_latch      = 1'b0;
      w_timing_err = 1'b0;
      case (r_state)
         S_SYNC: begin
            if (r_din_s2) begin
               w_cnt_next = '0;
            end else if (r_cnt >= L_RST_LAST) begin
               w_state_next = S_IDLE;
               w_cnt_next   = '0;
            end else begin
               w_cnt_next = r_cnt + L_ONE;
            end
         end
         S_IDLE: begin
            if (w_rise) begin
               w_state_next = S_HIGH;
               w_cnt_next   = L_ONE;
            end
         end
         S_HIGH: begin
            if (w_fall) begin
               if (r_cnt < L_HMIN) begin
                  w_timing_err = 1'b1;
                  w_state_next = S_SYNC;
                  w_cnt_next   = '0;
               end else begin
                  w_bit_done   = 1'b1;
                  w_bit_val    = (r_cnt >= L_THRESH);
                  w_state_next = S_LOW;
                  w_cnt_next   = L_ONE;
               end
            end else if (r_cnt >= L_HMAX) begin
               // this cycle would be high-count T_HIGH_MAX+1: too long
               w_timing_err = 1'b1;
               w_state_next = S_SYNC;
               w_cnt_next   = '0;
            end else begin
               w_cnt_next = r_cnt + L_ONE;
            end
         end
         S_LOW: begin
            if (w_rise) begin
               w_state_next = S_HIGH;
               w_cnt_next   = L_ONE;
            end else if (r_cnt >= L_RST_LAST) begin
               w_latch      = 1'b1;
               w_state_next = S_IDLE;
               w_cnt_next   = '0;
            end else begin
               w_cnt_next = r_cnt + L_ONE;
            end
         end
         default: begin
            w_state_next = S_SYNC;
            w_cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_shift       <= '0;
         r_bitcnt      <= '0;
         r_index       <= '0;
         r_wr_en       <= 1'b0;
         r_wr_addr     <= '0;
         r_wr_data     <= '0;
         r_frame_done  <= 1'b0;
         r_pixel_count <= '0;
         r_busy        <= 1'b0;
         r_err         <= 1'b0;
         r_ovf         <= 1'b0;
      end else begin
         r_wr_en      <= 1'b0;
         r_frame_done <= 1'b0;
         // clear first so a coincident error event below wins
         if (i_err_clr) begin
            r_err <= 1'b0;
            r_ovf <= 1'b0;
         end
         if (r_state == S_IDLE && w_rise) begin
            r_busy <= 1'b1;
         end
         if (w_timing_err) begin
            r_err    <= 1'b1;
            r_busy   <= 1'b0;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_index  <= '0;
         end
         if (w_bit_done) begin
            r_shift <= w_shift_next;
            if (r_bitcnt == 5'd23) begin
               r_bitcnt <= '0;
               if (r_index == L_NPIX) begin
                  r_ovf <= 1'b1;
               end else begin
                  r_wr_en   <= 1'b1;
                  r_wr_data <= w_shift_next;
                  r_wr_addr <= r_index[ADDR_W-1:0];
                  r_index   <= r_index + 1'b1;
               end
            end else begin
               r_bitcnt <= r_bitcnt + 5'd1;
            end
         end
         if (w_latch) begin
            r_frame_done  <= 1'b1;
            r_pixel_count <= r_index;
            r_busy        <= 1'b0;
            r_index       <= '0;
            r_bitcnt      <= '0;
            if (r_bitcnt != 5'd0) begin
               r_err <= 1'b1;
            end
         end
      end
   end

   assign o_wr_addr     = r_wr_addr;
   assign o_wr_en       = r_wr_en;
   assign o_wr_data     = r_wr_data;
   assign o_frame_done  = r_frame_done;
   assign o_pixel_count = r_pixel_count;
   assign o_busy        = r_busy;
   assign o_err         = r_err;
   assign o_ovf         = r_ovf;

endmodule

// File: tb/tb_neopixel_rx.sv
// Directed bench for neopixel_rx: bench-generated WS2812 waveforms, write capture
// from the port, and per-scenario checks against hand-computed values.
module tb_neopixel_rx;
   localparam int ADDR_W = 8;

   logic              i_clk = 1'b0;
   logic              i_reset = 1'b1;
   logic              i_din = 1'b0;
   logic              i_err_clr = 1'b0;
   logic [ADDR_W-1:0] o_wr_addr;
   logic              o_wr_en;
   logic [23:0]       o_wr_data;
   logic              o_frame_done;
   logic [ADDR_W:0]   o_pixel_count;
   logic              o_busy, o_err, o_ovf;

   int checks = 0;
   int errors = 0;
   int hi1 = 40, hi0 = 20, period = 62;

   logic [ADDR_W-1:0] cap_addr[$];
   logic [23:0]       cap_data[$];
   int                fd_cnt = 0;
   bit                both_seen = 1'b0;

   always #5 i_clk = ~i_clk;

   neopixel_rx #(.N_PIXELS(4), .ADDR_W(ADDR_W)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_din(i_din), .i_err_clr(i_err_clr),
      .o_wr_addr(o_wr_addr), .o_wr_en(o_wr_en), .o_wr_data(o_wr_data),
      .o_frame_done(o_frame_done), .o_pixel_count(o_pixel_count),
      .o_busy(o_busy), .o_err(o_err), .o_ovf(o_ovf)
   );

   always @(negedge i_clk) begin
      if (o_wr_en) begin
         cap_addr.push_back(o_wr_addr);
         cap_data.push_back(o_wr_data);
      end
      if (o_frame_done) fd_cnt++;
      if (o_wr_en && o_frame_done) both_seen = 1'b1;
   end

   task automatic clear_capture();
      cap_addr.delete();
      cap_data.delete();
      fd_cnt = 0;
   endtask

   task automatic send_level(input logic v, input int n);
      i_din = v;
      repeat (n) @(negedge i_clk);
   endtask

   task automatic send_bit(input logic b);
      int h;
      h = b ? hi1 : hi0;
      send_level(1'b1, h);
      send_level(1'b0, period - h);
   endtask

   task automatic send_pixel(input logic [23:0] p);
      for (int i = 23; i >= 0; i--) send_bit(p[i]);
   endtask

   task automatic pulse_err_clr();
      i_err_clr = 1'b1;
      @(negedge i_clk);
      i_err_clr = 1'b0;
      @(negedge i_clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge i_clk);
      checks++;
      if ({o_wr_addr, o_wr_en, o_wr_data, o_frame_done, o_pixel_count, o_busy, o_err, o_ovf} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got addr=%h en=%b data=%h fd=%b cnt=%0d busy=%b err=%b ovf=%b, want all 0",
                  o_wr_addr, o_wr_en, o_wr_data, o_frame_done, o_pixel_count, o_busy, o_err, o_ovf);
      end
      i_reset = 1'b0;
      send_level(1'b0, 2490);
      send_level(1'b1, 40);
      checks++;
      if (o_busy !== 1'b0) begin
         errors++;
         $display("FAIL sync_pulse_ignored: busy=%b want 0", o_busy);
      end
      send_level(1'b0, 100);
      checks++;
      if (cap_addr.size() != 0 || o_err !== 1'b0) begin
         errors++;
         $display("FAIL sync_no_write: writes=%0d err=%b want 0/0", cap_addr.size(), o_err);
      end
   endtask

   task automatic test_single_pixel();
      clear_capture();
      send_level(1'b0, 2510);
      send_bit(1'b1);
      checks++;
      if (o_busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_mid_pixel: busy=%b want 1", o_busy);
      end
      for (int i = 22; i >= 0; i--) send_bit(1'(24'hFF0055 >> i));
      checks++;
      if (cap_addr.size() != 1 || cap_addr[0] !== 8'd0 || cap_data[0] !== 24'hFF0055) begin
         errors++;
         $display("FAIL single_pixel: writes=%0d addr=%h data=%h want 1/00/ff0055",
                  cap_addr.size(), (cap_addr.size() > 0) ? cap_addr[0] : 8'hxx,
                  (cap_data.size() > 0) ? cap_data[0] : 24'hxxxxxx);
      end
      send_level(1'b0, 2510);
      checks++;
      if (fd_cnt != 1 || o_pixel_count !== 9'd1 || o_busy !== 1'b0 || o_err !== 1'b0) begin
         errors++;
         $display("FAIL single_latch: fd=%0d cnt=%0d busy=%b err=%b want 1/1/0/0",
                  fd_cnt, o_pixel_count, o_busy, o_err);
      end
   endtask

   task automatic test_loopback();
      logic [23:0] px[3];
      px[0] = 24'h123456; px[1] = 24'hABCDEF; px[2] = 24'h000001;
      hi1 = 35; hi0 = 18; period = 63;
      clear_capture();
      for (int p = 0; p < 3; p++) send_pixel(px[p]);
      send_level(1'b0, 2510);
      for (int p = 0; p < 3; p++) begin
         checks++;
         if (cap_addr.size() <= p || cap_addr[p] !== 8'(p) || cap_data[p] !== px[p]) begin
            errors++;
            $display("FAIL loopback_px%0d: addr=%h data=%h want %h/%h", p,
                     (cap_addr.size() > p) ? cap_addr[p] : 8'hxx,
                     (cap_data.size() > p) ? cap_data[p] : 24'hxxxxxx, 8'(p), px[p]);
         end
      end
      checks++;
      if (cap_addr.size() != 3 || fd_cnt != 1 || o_pixel_count !== 9'd3) begin
         errors++;
         $display("FAIL loopback_frame: writes=%0d fd=%0d cnt=%0d want 3/1/3",
                  cap_addr.size(), fd_cnt, o_pixel_count);
      end
      clear_capture();
      send_pixel(24'hC0FFEE);
      send_level(1'b0, 2510);
      checks++;
      if (cap_addr.size() != 1 || cap_addr[0] !== 8'd0 || cap_data[0] !== 24'hC0FFEE ||
          o_err !== 1'b0 || o_pixel_count !== 9'd1) begin
         errors++;
         $display("FAIL loopback_frame2: writes=%0d err=%b cnt=%0d want 1 write at 00 of c0ffee, err 0, cnt 1",
                  cap_addr.size(), o_err, o_pixel_count);
      end
      hi1 = 40; hi0 = 20; period = 62;
   endtask

   task automatic test_timing_errors();
      clear_capture();
      send_level(1'b1, 3);
      send_level(1'b0, 10);
      checks++;
      if (o_err !== 1'b1 || cap_addr.size() != 0 || o_busy !== 1'b0) begin
         errors++;
         $display("FAIL glitch: err=%b writes=%0d busy=%b want 1/0/0", o_err, cap_addr.size(), o_busy);
      end
      pulse_err_clr();
      checks++;
      if (o_err !== 1'b0) begin
         errors++;
         $display("FAIL err_clr1: err=%b want 0", o_err);
      end
      send_level(1'b0, 2510);
      send_level(1'b1, 70);
      checks++;
      if (o_err !== 1'b1 || o_busy !== 1'b0) begin
         errors++;
         $display("FAIL long_high: err=%b busy=%b want 1/0", o_err, o_busy);
      end
      send_level(1'b0, 2510);
      send_pixel(24'h00FF00);
      checks++;
      if (cap_addr.size() != 1 || cap_addr[0] !== 8'd0 || cap_data[0] !== 24'h00FF00) begin
         errors++;
         $display("FAIL recover_pixel: writes=%0d data=%h want 1 write of 00ff00", cap_addr.size(),
                  (cap_data.size() > 0) ? cap_data[0] : 24'hxxxxxx);
      end
      pulse_err_clr();
      send_level(1'b0, 2510);
      checks++;
      if (o_err !== 1'b0 || fd_cnt != 1 || o_pixel_count !== 9'd1) begin
         errors++;
         $display("FAIL err_clr2: err=%b fd=%0d cnt=%0d want 0/1/1", o_err, fd_cnt, o_pixel_count);
      end
   endtask

   task automatic test_partial_pixel();
      clear_capture();
      for (int i = 11; i >= 0; i--) send_bit(1'(12'hABC >> i));
      send_level(1'b0, 2510);
      checks++;
      if (cap_addr.size() != 0 || fd_cnt != 1 || o_pixel_count !== 9'd0 || o_err !== 1'b1) begin
         errors++;
         $display("FAIL partial: writes=%0d fd=%0d cnt=%0d err=%b want 0/1/0/1",
                  cap_addr.size(), fd_cnt, o_pixel_count, o_err);
      end
      pulse_err_clr();
   endtask

   task automatic test_overflow();
      clear_capture();
      for (int p = 0; p < 5; p++) send_pixel(24'h111111 * (p + 1));
      checks++;
      if (o_ovf !== 1'b1) begin
         errors++;
         $display("FAIL ovf_flag: ovf=%b want 1", o_ovf);
      end
      send_level(1'b0, 2510);
      for (int p = 0; p < 4; p++) begin
         checks++;
         if (cap_addr.size() <= p || cap_addr[p] !== 8'(p) || cap_data[p] !== 24'h111111 * (p + 1)) begin
            errors++;
            $display("FAIL ovf_px%0d: got addr=%h data=%h", p,
                     (cap_addr.size() > p) ? cap_addr[p] : 8'hxx,
                     (cap_data.size() > p) ? cap_data[p] : 24'hxxxxxx);
         end
      end
      checks++;
      if (cap_addr.size() != 4 || o_pixel_count !== 9'd4 || fd_cnt != 1 || o_err !== 1'b0) begin
         errors++;
         $display("FAIL ovf_frame: writes=%0d cnt=%0d fd=%0d err=%b want 4/4/1/0",
                  cap_addr.size(), o_pixel_count, fd_cnt, o_err);
      end
      pulse_err_clr();
      checks++;
      if (o_ovf !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clr: ovf=%b want 0", o_ovf);
      end
   endtask

   task automatic test_async_reset();
      clear_capture();
      send_level(1'b0, 2510);
      for (int i = 0; i < 10; i++) send_bit(i[0]);
      send_level(1'b1, 10);
      #2 i_reset = 1'b1;
      #1;
      checks++;
      if ({o_wr_addr, o_wr_en, o_wr_data, o_frame_done, o_pixel_count, o_busy, o_err, o_ovf} !== '0) begin
         errors++;
         $display("FAIL async_reset_outputs: cnt=%0d busy=%b err=%b ovf=%b want all 0",
                  o_pixel_count, o_busy, o_err, o_ovf);
      end
      @(negedge i_clk);
      i_reset = 1'b0;
      send_level(1'b0, 30);
      for (int i = 0; i < 14; i++) send_bit(1'b1);
      checks++;
      if (cap_addr.size() != 0 || o_busy !== 1'b0) begin
         errors++;
         $display("FAIL async_reset_sync: writes=%0d busy=%b want 0/0", cap_addr.size(), o_busy);
      end
      send_level(1'b0, 2510);
      checks++;
      if (fd_cnt != 0 || o_err !== 1'b0) begin
         errors++;
         $display("FAIL async_reset_no_latch: fd=%0d err=%b want 0/0", fd_cnt, o_err);
      end
   endtask

   task automatic test_exclusive_strobes();
      checks++;
      if (both_seen !== 1'b0) begin
         errors++;
         $display("FAIL strobe_overlap: wr_en and frame_done seen together=%b want 0", both_seen);
      end
   endtask

   initial begin
      test_reset();
      test_single_pixel();
      test_loopback();
      test_timing_errors();
      test_partial_pixel();
      test_overflow();
      test_async_reset();
      test_exclusive_strobes();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
